// File: rtl/mlp_seq_engine.sv
// Sequential two-layer MLP: one shared signed MAC walks layer 1 (ReLU into a
// hidden register file) then layer 2 (linear outputs), driven by a 4-state FSM.
// Weights live in a small register file that is writable only while idle.
module mlp_seq_engine #(
  parameter int N_IN  = 4,
  parameter int N_HID = 4,
  parameter int N_OUT = 2,
  parameter int DW    = 5,
  localparam int HW = 2*DW + $clog2(N_IN),
  localparam int OW = HW + DW + $clog2(N_HID),
  localparam int NW = N_IN*N_HID + N_HID*N_OUT,
  localparam int AW = $clog2(NW)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_wr_en,
  input  logic [AW-1:0]         w_wr_addr,
  input  logic [DW-1:0]         w_wr_data,
  output logic                  w_err,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_IN*DW-1:0]    in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N_OUT*OW-1:0]   out_data,
  output logic                  busy
);

  localparam int IW  = $clog2(N_IN);
  localparam int HIW = $clog2(N_HID);
  localparam int OIW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  typedef enum logic [1:0] {IDLE, L1, L2, DONE} state_e;

  state_e               state_q, state_d;
  logic signed [DW-1:0] w_q   [NW];
  logic signed [DW-1:0] w_d   [NW];
  logic signed [DW-1:0] x_q   [N_IN];
  logic signed [DW-1:0] x_d   [N_IN];
  logic signed [HW-1:0] hid_q [N_HID];
  logic signed [HW-1:0] hid_d [N_HID];
  logic signed [OW-1:0] acc_q, acc_d;
  logic [N_OUT*OW-1:0]  out_q, out_d;
  logic [IW-1:0]        i_q, i_d;
  logic [HIW-1:0]       h_q, h_d;
  logic [OIW-1:0]       o_q, o_d;
  logic                 w_err_q, w_err_d;

  logic [AW-1:0]           a1, a2;
  logic signed [2*DW-1:0]  p1;
  logic signed [HW+DW-1:0] p2;
  logic signed [OW-1:0]    mac1, mac2;

  // MAC operand fetch for both layers; the FSM picks which sum to keep
  always_comb begin
    a1   = AW'(int'(i_q)*N_HID + int'(h_q));
    a2   = AW'(N_IN*N_HID + int'(h_q)*N_OUT + int'(o_q));
    p1   = x_q[i_q] * w_q[a1];
    p2   = hid_q[h_q] * w_q[a2];
    mac1 = acc_q + OW'(p1);
    mac2 = acc_q + OW'(p2);
  end

  // Next-state: weight port, FSM sequencing, accumulator and result capture
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    x_d     = x_q;
    hid_d   = hid_q;
    acc_d   = acc_q;
    out_d   = out_q;
    i_d     = i_q;
    h_d     = h_q;
    o_d     = o_q;
    w_err_d = w_err_q;

    // Writes are only safe while nothing reads the weights; anything else is
    // dropped and remembered until reset.
    if (w_wr_en) begin
      if (state_q == IDLE && int'(w_wr_addr) < NW) w_d[w_wr_addr] = w_wr_data;
      else                                         w_err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int k = 0; k < N_IN; k++) x_d[k] = in_data[k*DW +: DW];
          acc_d   = '0;
          i_d     = '0;
          h_d     = '0;
          o_d     = '0;
          state_d = L1;
        end
      end
      L1: begin
        acc_d = mac1;
        if (i_q == IW'(N_IN-1)) begin
          hid_d[h_q] = mac1[OW-1] ? {HW{1'b0}} : mac1[HW-1:0];
          acc_d      = '0;
          i_d        = '0;
          if (h_q == HIW'(N_HID-1)) begin
            h_d     = '0;
            state_d = L2;
          end else begin
            h_d = h_q + 1'b1;
          end
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      L2: begin
        acc_d = mac2;
        if (h_q == HIW'(N_HID-1)) begin
          out_d[int'(o_q)*OW +: OW] = mac2;
          acc_d = '0;
          h_d   = '0;
          if (o_q == OIW'(N_OUT-1)) begin
            o_d     = '0;
            state_d = DONE;
          end else begin
            o_d = o_q + 1'b1;
          end
        end else begin
          h_d = h_q + 1'b1;
        end
      end
      DONE: begin
        // Returning to IDLE first keeps an accept out of the handoff cycle
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset clears everything, including the weight file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      for (int k = 0; k < NW; k++)    w_q[k]   <= '0;
      for (int k = 0; k < N_IN; k++)  x_q[k]   <= '0;
      for (int k = 0; k < N_HID; k++) hid_q[k] <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      i_q     <= '0;
      h_q     <= '0;
      o_q     <= '0;
      w_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      x_q     <= x_d;
      hid_q   <= hid_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      i_q     <= i_d;
      h_q     <= h_d;
      o_q     <= o_d;
      w_err_q <= w_err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == L1) || (state_q == L2);
  assign out_data  = out_q;
  assign w_err     = w_err_q;

endmodule

// File: tb/tb_mlp_seq_engine.sv
// Directed bench for mlp_seq_engine at default parameters (4-4-2, DW=5).
module tb_mlp_seq_engine;

  localparam int OW = 19;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        w_wr_en = 1'b0;
  logic [4:0]  w_wr_addr = '0;
  logic [4:0]  w_wr_data = '0;
  logic        w_err;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [19:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [37:0] out_data;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int t0 = 0;
  logic [37:0] held;

  mlp_seq_engine dut (
    .clk(clk), .rst_n(rst_n),
    .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data), .w_err(w_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] px(input int a, input int b, input int c, input int d);
    return {5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  function automatic logic [37:0] py(input int y0, input int y1);
    return {19'(y1), 19'(y0)};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic write_w(input int a, input int d);
    w_wr_en = 1'b1; w_wr_addr = 5'(a); w_wr_data = 5'(d);
    step();
    w_wr_en = 1'b0;
  endtask

  task automatic load_all(input int v1, input int v2);
    for (int a = 0; a < 24; a++) write_w(a, (a < 16) ? v1 : v2);
  endtask

  // Present a vector in IDLE, accept it, then scramble in_data
  task automatic start(input string tag, input logic [19:0] x);
    chk({tag, "_rdy"}, in_ready, 1);
    in_data = x; in_valid = 1'b1;
    step();
    t0 = cyc;
    in_valid = 1'b0; in_data = ~x;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_nrdy"}, in_ready, 0);
  endtask

  task automatic wait_done(input string tag, input logic [37:0] exp);
    while (!out_valid && (cyc - t0) < 100) step();
    chk({tag, "_lat"}, 64'(cyc - t0), 24);
    chk({tag, "_y"}, out_data, exp);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_idle"}, in_ready, 1);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_ov", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_werr", w_err, 0);
    chk("rst_y", out_data, 0);
    #20 rst_n = 1'b1;
    step();
    chk("rst_rdy", in_ready, 1);

    // All weights 1, x=(1,2,3,4): hidden 10, y=40
    load_all(1, 1);
    chk("ones_werr", w_err, 0);
    start("ones", px(1, 2, 3, 4));
    wait_done("ones", py(40, 40));
    release_out("ones");

    // Negative layer-1 sums clamp to 0
    load_all(-1, 1);
    start("relu", px(1, 1, 1, 1));
    wait_done("relu", py(0, 0));
    release_out("relu");

    // Outputs are linear: negative results pass through
    load_all(1, -1);
    start("lin", px(1, 2, 3, 4));
    wait_done("lin", py(-40, -40));
    release_out("lin");

    // Address map: w1 identity, w2[h][0]=h+1, w2[h][1]=1 except w2[3][1]=-3
    // x=(1,-2,3,4) -> hidden (1,0,3,4), y0=1+9+16=26, y1=1+3-12=-8
    for (int i = 0; i < 4; i++)
      for (int h = 0; h < 4; h++) write_w(i*4 + h, (i == h) ? 1 : 0);
    for (int h = 0; h < 4; h++) begin
      write_w(16 + h*2, h + 1);
      write_w(17 + h*2, (h == 3) ? -3 : 1);
    end
    start("map", px(1, -2, 3, 4));
    wait_done("map", py(26, -8));
    release_out("map");

    // Extremes: -16 everywhere -> hidden 1024, y=-65536
    load_all(-16, -16);
    start("ext", px(-16, -16, -16, -16));
    wait_done("ext", py(-65536, -65536));
    release_out("ext");

    // Backpressure: hold out_ready low 10 cycles with in_valid pending
    load_all(1, 1);
    start("bp", px(1, 2, 3, 4));
    wait_done("bp", py(40, 40));
    held = out_data;
    in_data = px(2, 2, 2, 2); in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("bp_hold_y", out_data, held);
      chk("bp_hold_ov", out_valid, 1);
      chk("bp_hold_rdy", in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_noacc_busy", busy, 0);
    chk("bp_noacc_rdy", in_ready, 1);
    step();
    t0 = cyc;
    in_valid = 1'b0;
    chk("bp_acc_busy", busy, 1);
    // hidden 8 each, y=32
    wait_done("bp2", py(32, 32));
    release_out("bp2");

    // Write during L1 dropped and flagged; result unchanged
    start("l1w", px(1, 2, 3, 4));
    step(); step();
    write_w(0, -16);
    chk("l1w_err", w_err, 1);
    wait_done("l1w", py(40, 40));
    release_out("l1w");
    start("l1w_chk", px(1, 2, 3, 4));
    wait_done("l1w_chk", py(40, 40));
    release_out("l1w_chk");

    // Reset mid-L1 aborts; weights and error flag cleared
    start("abort", px(1, 2, 3, 4));
    for (int k = 0; k < 6; k++) step();
    rst_n = 1'b0;
    #2;
    chk("abort_busy", busy, 0);
    chk("abort_werr", w_err, 0);
    chk("abort_y", out_data, 0);
    rst_n = 1'b1;
    begin
      int seen = 0;
      for (int k = 0; k < 30; k++) begin
        step();
        if (out_valid) seen++;
      end
      chk("abort_no_ov", 64'(seen), 0);
    end
    chk("abort_rdy", in_ready, 1);
    start("zw", px(1, 2, 3, 4));
    wait_done("zw", py(0, 0));
    release_out("zw");

    // Out-of-range address in IDLE dropped and flagged
    write_w(24, 5);
    chk("oob_err", w_err, 1);
    start("oob", px(1, 2, 3, 4));
    wait_done("oob", py(0, 0));
    release_out("oob");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mlp_seq_engine.md
MLP_SEQ_ENGINE -- requirements
Module: mlp_seq_engine

Interface
REQ-001 Parameter N_IN, default 4: input vector length (2 to 16).
REQ-002 Parameter N_HID, default 4: hidden neuron count (2 to 16).
REQ-003 Parameter N_OUT, default 2: output neuron count (1 to 8).
REQ-004 Parameter DW, default 5: signed width of inputs and weights.
REQ-005 Derived widths SHALL be: HW = 2*DW + clog2(N_IN) for hidden values; OW = HW + DW + clog2(N_HID) for outputs; NW = N_IN*N_HID + N_HID*N_OUT weights; AW = clog2(NW).
REQ-006 clk  input  1  single clock, all state on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 w_wr_en  input  1  weight write strobe.
REQ-009 w_wr_addr  input  AW  weight address.
REQ-010 w_wr_data  input  DW  signed weight value.
REQ-011 w_err  output  1  sticky flag, set on any ignored weight write.
REQ-012 in_valid  input  1  input vector valid.
REQ-013 in_ready  output  1  engine can accept an input vector.
REQ-014 in_data  input  N_IN*DW  packed signed x[i] at bits [i*DW +: DW].
REQ-015 out_valid  output  1  result valid.
REQ-016 out_ready  input  1  consumer accepts result.
REQ-017 out_data  output  N_OUT*OW  packed signed y[o] at bits [o*OW +: OW].
REQ-018 busy  output  1  high in L1 or L2 state.

Function
REQ-019 Weight map: layer-1 weight w1[i][h] SHALL sit at address i*N_HID + h; layer-2 weight w2[h][o] at N_IN*N_HID + h*N_OUT + o.
REQ-020 A weight write SHALL take effect only in IDLE with w_wr_addr < NW; any other write SHALL be dropped and set w_err, which clears only on reset.
REQ-021 A weight write coinciding with an input accept SHALL be applied and used by that computation.
REQ-022 FSM states: IDLE, L1, L2, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-023 IDLE: on in_valid & in_ready, in_data SHALL be registered, the accumulator cleared, and the state moved to L1.
REQ-024 L1: one signed MAC per cycle, hidden index h outer, input index i inner; after i = N_IN-1, hidden[h] SHALL store ReLU(acc), i.e. 0 if negative, else acc, in HW bits, and acc SHALL clear.
REQ-025 L1 SHALL last exactly N_IN*N_HID cycles, then move to L2.
REQ-026 L2: one MAC per cycle, output o outer, hidden h inner, using hidden[h]*w2[h][o]; after h = N_HID-1, y[o] SHALL be written to out_data; no activation on outputs.
REQ-027 L2 SHALL last exactly N_HID*N_OUT cycles, then move to DONE.
REQ-028 out_valid SHALL rise exactly N_IN*N_HID + N_HID*N_OUT cycles after the accepting edge (24 at default parameters).
REQ-029 DONE: out_data and out_valid SHALL hold stable until out_ready is high, then move to IDLE; a new input SHALL NOT be accepted in the same cycle.
REQ-030 All arithmetic SHALL be full-precision signed at the derived widths; no overflow or saturation is possible.
REQ-031 in_valid outside IDLE SHALL be ignored, and in_data changes SHALL NOT affect a computation in progress.

Reset
REQ-032 While rst_n is low, regardless of state: state=IDLE, all weights=0, hidden=0, acc=0, out_data=0, out_valid=0, busy=0, w_err=0; in_ready SHALL be 1 from the first edge after release.
REQ-033 Reset asserted mid-computation SHALL abort it, and no out_valid SHALL follow.

Verification
REQ-034 All weights 1, x=(1,2,3,4) -> out_valid at cycle 24 after accept, y0=y1=40.
REQ-035 All w1=-1, all w2=1, x=(1,1,1,1) -> hidden all 0 after ReLU, y0=y1=0.
REQ-036 Extremes: all weights and x = -16 -> hidden 1024 each, y0=y1=-65536 with no wrap.
REQ-037 out_ready held low 10 cycles after out_valid -> out_data is stable and in_ready stays 0; accept only after the out_ready cycle.
REQ-038 Weight write during L1, plus write to address 24 in IDLE -> both dropped, w_err=1, results unchanged.
REQ-039 rst_n pulsed low at L1 cycle 7 -> out_valid never asserts, weights read back as zero (all-zero result on next run), in_ready=1.
